// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan FSM states, dark-display codes and the active-low hex glyph table.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHOW,
    BLANK
  } state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
module hex_to_seg
  import seg_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] value,
  output logic [6:0]        seg
);

  logic [3:0] nibble;

  assign nibble = 4'(value);
  assign seg    = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Optional macro BRIGHTNESS_EN adds a brightness[2:0] input that trims the lit part of each dwell.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DATA_W       = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef BRIGHTNESS_EN
  input  logic [2:0]            brightness,
`endif
  output logic [2:0]            rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [6:0]            seg_output,
  output logic [7:0]            anode_pins,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  state_t            state, state_d;
  logic [2:0]        index, index_d;
  logic [CNT_W-1:0]  count, count_d;
  logic [DATA_W-1:0] value, value_d;
  logic [2:0]        addr_d;
  logic              frame_d;
  logic              advance;
  logic [6:0]        glyph;
  logic [6:0]        seg_d;
  logic [7:0]        anode_d;
  logic [7:0]        mask_full;
  logic              dim_ok;

  assign mask_full = 8'(digit_mask);

  // Decoding the value register's D input lets the segment outputs be
  // registered without costing an extra cycle of latency.
  hex_to_seg #(.DATA_W(DATA_W)) u_hex_to_seg (
    .value (value_d),
    .seg   (glyph)
  );

`ifdef BRIGHTNESS_EN
  localparam int PW = CNT_W + 3;
  logic [PW-1:0] bright_prod;

  assign bright_prod = (PW'(brightness) + PW'(1)) * PW'(DWELL_CYCLES);
  assign dim_ok      = PW'(count_d) < (bright_prod >> 3);
`else
  assign dim_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state;
    index_d = index;
    count_d = count;
    value_d = value;
    addr_d  = rd_addr;
    frame_d = 1'b0;
    advance = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      index_d = '0;
      count_d = '0;
      addr_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = FETCH;
          index_d = '0;
          count_d = '0;
          addr_d  = '0;
        end
        FETCH: begin
          value_d = rd_data;
          state_d = SHOW;
          count_d = '0;
        end
        SHOW: begin
          if (count == DWELL_LAST) begin
            if (BLANK_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              state_d = BLANK;
              count_d = '0;
            end
          end else begin
            count_d = count + 1'b1;
          end
        end
        BLANK: begin
          if (count == BLANK_LAST) advance = 1'b1;
          else                     count_d = count + 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        index_d = (index == LAST_IDX) ? 3'd0 : index + 3'd1;
        frame_d = (index == LAST_IDX);
        state_d = FETCH;
        count_d = '0;
        addr_d  = index_d;
      end
    end

    // Outputs follow the next state so they change on the same edge as it.
    seg_d   = (state_d == SHOW) ? glyph : SEG_OFF;
    anode_d = ANODE_OFF;
    if (state_d == SHOW && mask_full[index_d] && dim_ok) anode_d[index_d] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      count      <= '0;
      value      <= '0;
      rd_addr    <= '0;
      seg_output <= SEG_OFF;
      anode_pins <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      index      <= index_d;
      count      <= count_d;
      value      <= value_d;
      rd_addr    <= addr_d;
      seg_output <= seg_d;
      anode_pins <= anode_d;
      frame_done <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle expected outputs are queued
// from a visit-level model of the scan and compared as the DUT produces them.
module tb_seg_scan_ctrl;

  localparam int ND = 8;
`ifdef BRIGHTNESS_EN
  localparam int DWELL = 8;
`else
  localparam int DWELL = 4;
`endif
  localparam int BLANK  = 2;
  localparam int PERIOD = 1 + DWELL + BLANK;
  localparam int FRAME  = ND * PERIOD;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [ND-1:0] digit_mask;
  logic [2:0]    brightness;
  logic [2:0]    rd_addr;
  logic [3:0]    rd_data;
  logic [6:0]    seg_output;
  logic [7:0]    anode_pins;
  logic          frame_done;

  logic [3:0] mem [ND];
  assign rd_data = mem[rd_addr];

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DATA_W       (4),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
`ifdef BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .seg_output (seg_output),
    .anode_pins (anode_pins),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       fd;
    logic [2:0] addr;
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'b1000000;  4'h1: ref_seg = 7'b1111001;
      4'h2: ref_seg = 7'b0100100;  4'h3: ref_seg = 7'b0110000;
      4'h4: ref_seg = 7'b0011001;  4'h5: ref_seg = 7'b0010010;
      4'h6: ref_seg = 7'b0000010;  4'h7: ref_seg = 7'b1111000;
      4'h8: ref_seg = 7'b0000000;  4'h9: ref_seg = 7'b0010000;
      4'hA: ref_seg = 7'b0001000;  4'hB: ref_seg = 7'b0000011;
      4'hC: ref_seg = 7'b1000110;  4'hD: ref_seg = 7'b0100001;
      4'hE: ref_seg = 7'b0000110;  default: ref_seg = 7'b0001110;
    endcase
  endfunction

  function automatic exp_t observed();
    observed = '{fd: frame_done, addr: rd_addr, an: anode_pins, seg: seg_output};
  endfunction

  function automatic int lit_cycles();
`ifdef BRIGHTNESS_EN
    lit_cycles = ((int'(brightness) + 1) * DWELL) >> 3;
`else
    lit_cycles = DWELL;
`endif
  endfunction

  // One visit: a dark fetch cycle, DWELL shown cycles, BLANK dark cycles.
  task automatic push_visit(input int d, input logic fd, input logic [3:0] v);
    int   lit_n;
    logic [7:0] lit_an;
    lit_n  = lit_cycles();
    lit_an = ~(8'b1 << d);
    q.push_back('{fd: fd, addr: 3'(d), an: 8'hFF, seg: 7'h7F});
    for (int c = 0; c < DWELL; c++)
      q.push_back('{fd: 1'b0, addr: 3'(d),
                    an: (digit_mask[d] && c < lit_n) ? lit_an : 8'hFF,
                    seg: ref_seg(v)});
    for (int c = 0; c < BLANK; c++)
      q.push_back('{fd: 1'b0, addr: 3'(d), an: 8'hFF, seg: 7'h7F});
  endtask

  task automatic push_frame(input logic fd0, input int ov_d, input logic [3:0] ov_v);
    for (int d = 0; d < ND; d++)
      push_visit(d, (d == 0) ? fd0 : 1'b0, (d == ov_d) ? ov_v : mem[d]);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    digit_mask = '1;
    brightness = 3'd7;
    for (int i = 0; i < ND; i++) mem[i] = 4'(i + 1);
    do_reset();
    checks++;
    if (seg_output !== 7'h7F) begin
      failures++; $display("FAIL reset_seg got=%h exp=7f", seg_output);
    end
    checks++;
    if (anode_pins !== 8'hFF) begin
      failures++; $display("FAIL reset_anode got=%h exp=ff", anode_pins);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done);
    end
    checks++;
    if (rd_addr !== 3'd0) begin
      failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== exp_t'({1'b0, 3'd0, 8'hFF, 7'h7F})) begin
      failures++; $display("FAIL idle_dark got=%h exp=%h", observed(), exp_t'({1'b0, 3'd0, 8'hFF, 7'h7F}));
    end
  endtask

  task automatic test_scan();
    int   pulses;
    exp_t e;
    pulses = 0;
    do_reset();
    enable = 1'b1;
    push_frame(1'b0, -1, 4'h0);
    push_frame(1'b1, -1, 4'h0);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      if (frame_done === 1'b1) pulses++;
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL scan_pulses got=%0d exp=1 over %0d cycles", pulses, 2 * FRAME);
    end
  endtask

  task automatic test_mask();
    int         pulses;
    logic [7:0] low_seen;
    exp_t       e;
    pulses     = 0;
    low_seen   = 8'h00;
    digit_mask = 8'b1111_0101;
    do_reset();
    enable = 1'b1;
    push_frame(1'b0, -1, 4'h0);
    push_frame(1'b1, -1, 4'h0);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      if (frame_done === 1'b1) pulses++;
      low_seen |= ~anode_pins;
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL mask cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
    checks++;
    if ((low_seen & 8'h0A) !== 8'h00) begin
      failures++; $display("FAIL mask_never_lit got=%h exp=00", low_seen & 8'h0A);
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL mask_frame_len got=%0d pulses exp=1", pulses);
    end
    digit_mask = '1;
  endtask

  task automatic test_stale();
    exp_t e;
    do_reset();
    enable = 1'b1;
    push_frame(1'b0, -1, 4'h0);
    push_frame(1'b1, 2, 4'h9);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL stale cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
      if (cyc == 2 * PERIOD + 2) mem[2] = 4'h9;
    end
    mem[2] = 4'h3;
  endtask

  task automatic test_enable_drop();
    exp_t e;
    do_reset();
    enable = 1'b1;
    repeat (5 * PERIOD + 3) @(posedge clk);
    #1;
    checks++;
    if (anode_pins !== 8'hDF) begin
      failures++; $display("FAIL drop_pre_lit got=%h exp=df", anode_pins);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp_t'({1'b0, 3'd0, 8'hFF, 7'h7F})) begin
        failures++; $display("FAIL drop_dark cyc=%0d got=%h exp=%h", i, observed(), exp_t'({1'b0, 3'd0, 8'hFF, 7'h7F}));
      end
    end
    enable = 1'b1;
    push_frame(1'b0, -1, 4'h0);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    repeat (PERIOD + 3) @(posedge clk);
    #1;
    checks++;
    if (anode_pins !== 8'hFD) begin
      failures++; $display("FAIL async_pre_lit got=%h exp=fd", anode_pins);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({anode_pins, seg_output} !== {8'hFF, 7'h7F}) begin
      failures++; $display("FAIL async_dark got=%h/%h exp=ff/7f", anode_pins, seg_output);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

`ifdef BRIGHTNESS_EN
  task automatic test_brightness();
    exp_t e;
    do_reset();
    brightness = 3'd3;
    enable     = 1'b1;
    push_frame(1'b0, -1, 4'h0);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL bright3 cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
    brightness = 3'd7;
    push_frame(1'b1, -1, 4'h0);
    for (int cyc = 0; q.size() != 0; cyc++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++; $display("FAIL bright7 cyc=%0d got=%h exp=%h", cyc, observed(), e);
      end
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    digit_mask = '1;
    brightness = 3'd7;
    test_reset();
    test_scan();
    test_mask();
    test_stale();
    test_enable_drop();
    test_async_reset();
`ifdef BRIGHTNESS_EN
    test_brightness();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
